// File: rtl/spike_vote_argmax.sv
// Accumulates classifier spike votes per class over a programmed number of RBM
// iterations, then scans the vote counters one class per cycle to find the argmax.
module spike_vote_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int CNT_W       = 8,
  parameter int ITER_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ITER_W-1:0] iter_num_i,
  input  logic              spike_valid_i,
  input  logic              spike_i,
  input  logic [3:0]        spike_class_i,
  input  logic              iter_end_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [3:0]        pred_class_o,
  output logic [CNT_W-1:0]  pred_count_o,
  output logic              tie_o,
  output logic              err_o
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCAN, S_DONE} state_e;

  state_e                              state_q;
  logic [NUM_CLASSES-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [ITER_W-1:0]                   iter_cnt_q, iter_tgt_q, iter_cnt_d;
  logic [3:0]                          scan_idx_q, best_idx_q, cand_idx;
  logic [CNT_W-1:0]                    best_cnt_q, cand_cnt, cur_cnt;
  logic                                best_tie_q, cand_tie, err_run_q;
  logic                                busy_q, done_q, tie_q, err_q;
  logic [3:0]                          pred_class_q;
  logic [CNT_W-1:0]                    pred_count_q;
  logic                                accept_start, in_range, count_en;

  assign accept_start = (state_q == S_IDLE) && start_i;
  // Five-bit compare keeps the range test correct even for NUM_CLASSES == 16.
  assign in_range     = {1'b0, spike_class_i} < 5'(NUM_CLASSES);
  assign count_en     = (state_q == S_ACCUM) && spike_valid_i && spike_i && in_range;
  assign iter_cnt_d   = iter_cnt_q + 1'b1;

  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_cnt
    assign cnt_d[gi] = accept_start ? '0 :
                       (count_en && (spike_class_i == 4'(gi)) && (cnt_q[gi] != {CNT_W{1'b1}}))
                       ? cnt_q[gi] + 1'b1 : cnt_q[gi];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cur_cnt = cnt_q[scan_idx_q];

  // Running argmax: lower index wins equal counts, a strictly larger count clears tie.
  always_comb begin
    cand_idx = best_idx_q;
    cand_cnt = best_cnt_q;
    cand_tie = best_tie_q;
    if (scan_idx_q == 4'd0) begin
      cand_idx = 4'd0;
      cand_cnt = cur_cnt;
      cand_tie = 1'b0;
    end else if (cur_cnt > best_cnt_q) begin
      cand_idx = scan_idx_q;
      cand_cnt = cur_cnt;
      cand_tie = 1'b0;
    end else if (cur_cnt == best_cnt_q) begin
      cand_tie = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      iter_cnt_q   <= '0;
      iter_tgt_q   <= '0;
      scan_idx_q   <= '0;
      best_idx_q   <= '0;
      best_cnt_q   <= '0;
      best_tie_q   <= 1'b0;
      err_run_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tie_q        <= 1'b0;
      err_q        <= 1'b0;
      pred_class_q <= '0;
      pred_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            iter_tgt_q <= iter_num_i;
            iter_cnt_q <= '0;
            scan_idx_q <= '0;
            err_run_q  <= 1'b0;
            tie_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= (iter_num_i == '0) ? S_SCAN : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (spike_valid_i && !in_range) err_run_q <= 1'b1;
          if (iter_end_i) begin
            iter_cnt_q <= iter_cnt_d;
            if (iter_cnt_d == iter_tgt_q) begin
              scan_idx_q <= '0;
              state_q    <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          best_idx_q <= cand_idx;
          best_cnt_q <= cand_cnt;
          best_tie_q <= cand_tie;
          if (scan_idx_q == LAST_IDX) begin
            pred_class_q <= cand_idx;
            pred_count_q <= cand_cnt;
            tie_q        <= cand_tie;
            err_q        <= err_run_q;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            scan_idx_q <= scan_idx_q + 1'b1;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pred_class_o = pred_class_q;
  assign pred_count_o = pred_count_q;
  assign tie_o        = tie_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_spike_vote_argmax.sv
// Bench for spike_vote_argmax: directed vector table, corner sequences and
// randomized runs checked against a vote-count/argmax reference model.
module tb_spike_vote_argmax;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] iter_num = '0;
  logic       spike_valid = 1'b0;
  logic       spike = 1'b0;
  logic [3:0] spike_class = '0;
  logic       iter_end = 1'b0;
  logic       busy, done, tie, err;
  logic [3:0] pred_class;
  logic [7:0] pred_count;

  spike_vote_argmax #(.NUM_CLASSES(10), .CNT_W(8), .ITER_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .iter_num_i(iter_num),
    .spike_valid_i(spike_valid), .spike_i(spike), .spike_class_i(spike_class),
    .iter_end_i(iter_end), .busy_o(busy), .done_o(done), .pred_class_o(pred_class),
    .pred_count_o(pred_count), .tie_o(tie), .err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Op byte: [7] spike_valid, [6] spike, [5] iter_end, [3:0] spike_class
  logic [7:0] ops_q[$];
  logic [3:0] prev_cls = '0;
  logic [7:0] prev_cnt = '0;
  logic [3:0] m_cls;
  logic [7:0] m_cnt;
  logic       m_tie, m_err;

  typedef struct {
    logic [7:0]  iter;
    int          n;
    logic [63:0] ops;
    logic        extra;
    logic [3:0]  e_cls;
    logic [7:0]  e_cnt;
    logic        e_tie;
    logic        e_err;
  } vec_t;

  vec_t tbl[7];

  function automatic vec_t mkvec(input logic [7:0] it, input int n, input logic [63:0] ops,
                                 input logic extra, input logic [3:0] c, input logic [7:0] k,
                                 input logic t, input logic e);
    vec_t v;
    v.iter = it; v.n = n; v.ops = ops; v.extra = extra;
    v.e_cls = c; v.e_cnt = k; v.e_tie = t; v.e_err = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference: plain vote tally with saturation, then argmax with lowest index.
  task automatic model();
    int cnt[10];
    int mx, nmx, c;
    foreach (cnt[i]) cnt[i] = 0;
    m_err = 1'b0;
    foreach (ops_q[j]) begin
      c = int'(ops_q[j][3:0]);
      if (ops_q[j][7]) begin
        if (c >= 10) m_err = 1'b1;
        else if (ops_q[j][6] && cnt[c] < 255) cnt[c]++;
      end
    end
    mx = -1; nmx = 0;
    for (int i = 0; i < 10; i++) if (cnt[i] > mx) begin mx = cnt[i]; m_cls = 4'(i); end
    for (int i = 0; i < 10; i++) if (cnt[i] == mx) nmx++;
    m_cnt = 8'(mx);
    m_tie = (nmx > 1);
  endtask

  task automatic drive_op(input logic [7:0] op);
    @(negedge clk);
    spike_valid = op[7]; spike = op[6]; iter_end = op[5]; spike_class = op[3:0];
    @(posedge clk); #1;
    spike_valid = 1'b0; spike = 1'b0; iter_end = 1'b0; spike_class = 4'($urandom_range(0, 15));
  endtask

  task automatic run_check(input string nm, input logic [7:0] it, input logic extra,
                           input logic [3:0] ec, input logic [7:0] ecnt,
                           input logic et, input logic ee);
    int lat;
    bit got;
    @(negedge clk);
    start = 1'b1; iter_num = it;
    @(posedge clk); #1;
    start = 1'b0; iter_num = 8'($urandom);
    chk({nm, "_busy_after_start"}, 32'(busy), 1);
    chk({nm, "_err_cleared"}, 32'(err), 0);
    chk({nm, "_tie_cleared"}, 32'(tie), 0);
    foreach (ops_q[j]) drive_op(ops_q[j]);
    got = 1'b0; lat = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk); #1;
      if (extra && k == 2) begin start = 1'b1; iter_num = 8'd5; end
      if (extra && k == 3) begin
        start = 1'b0;
        chk({nm, "_busy_ignores_start"}, 32'(busy), 1);
      end
      if (k == 5) chk({nm, "_pred_held_midrun"}, {20'd0, pred_class, pred_count}, {20'd0, prev_cls, prev_cnt});
      if (done) begin got = 1'b1; lat = k + 1; end
    end
    chk({nm, "_done_seen"}, 32'(got), 1);
    if (got) begin
      chk({nm, "_latency"}, 32'(lat), 11);
      chk({nm, "_pred_class"}, 32'(pred_class), 32'(ec));
      chk({nm, "_pred_count"}, 32'(pred_count), 32'(ecnt));
      chk({nm, "_tie"}, 32'(tie), 32'(et));
      chk({nm, "_err"}, 32'(err), 32'(ee));
      chk({nm, "_busy_at_done"}, 32'(busy), 0);
      @(posedge clk); #1;
      chk({nm, "_done_one_cycle"}, 32'(done), 0);
    end
    $display("run %s iter=%0d ops=%0d class=%0d count=%0d tie=%0d err=%0d lat=%0d",
             nm, it, ops_q.size(), pred_class, pred_count, tie, err, lat);
    prev_cls = ec; prev_cnt = ecnt;
  endtask

  initial begin
    int nit, nops;
    bit saw_done;
    logic [7:0] op;

    tbl[0] = mkvec(8'd1, 4, {32'h0, 8'h20, 8'hC7, 8'hC3, 8'hC3}, 1'b0, 4'd3, 8'd2, 1'b0, 1'b0);
    tbl[1] = mkvec(8'd2, 4, {32'h0, 8'hE5, 8'hE2, 8'hC2, 8'hC5}, 1'b0, 4'd2, 8'd2, 1'b1, 1'b0);
    tbl[2] = mkvec(8'd1, 3, {40'h0, 8'h20, 8'hC4, 8'hCC},        1'b0, 4'd4, 8'd1, 1'b0, 1'b1);
    tbl[3] = mkvec(8'd0, 0, 64'h0,                               1'b1, 4'd0, 8'd0, 1'b1, 1'b0);
    tbl[4] = mkvec(8'd1, 4, {32'h0, 8'h20, 8'hC1, 8'h4A, 8'h86}, 1'b0, 4'd1, 8'd1, 1'b0, 1'b0);
    tbl[5] = mkvec(8'd1, 1, {56'h0, 8'hE8},                      1'b0, 4'd8, 8'd1, 1'b0, 1'b0);
    tbl[6] = mkvec(8'd3, 3, {40'h0, 8'h20, 8'h20, 8'h20},        1'b0, 4'd0, 8'd0, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_pred_class", 32'(pred_class), 0);
    chk("reset_pred_count", 32'(pred_count), 0);
    chk("reset_tie", 32'(tie), 0);
    chk("reset_err", 32'(err), 0);
    rst_n = 1'b1;

    for (int t = 0; t < 7; t++) begin
      ops_q.delete();
      for (int j = 0; j < tbl[t].n; j++) ops_q.push_back(tbl[t].ops[8*j +: 8]);
      run_check($sformatf("vec%0d", t), tbl[t].iter, tbl[t].extra,
                tbl[t].e_cls, tbl[t].e_cnt, tbl[t].e_tie, tbl[t].e_err);
    end

    // Saturation: 300 votes on class 9 within one iteration.
    ops_q.delete();
    for (int j = 0; j < 300; j++) ops_q.push_back(8'hC9);
    ops_q.push_back(8'h20);
    run_check("saturate", 8'd1, 1'b0, 4'd9, 8'd255, 1'b0, 1'b0);

    // Reset during SCAN aborts the run with outputs forced to zero at once.
    @(negedge clk);
    start = 1'b1; iter_num = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    drive_op(8'hE2);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_pred_class", 32'(pred_class), 0);
    chk("abort_pred_count", 32'(pred_count), 0);
    chk("abort_tie_err", {30'd0, tie, err}, 0);
    saw_done = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 0);
    $display("run abort_in_scan busy=%0d done_seen=%0d", busy, saw_done);
    rst_n = 1'b1;
    prev_cls = '0; prev_cnt = '0;
    ops_q.delete();
    for (int j = 0; j < tbl[0].n; j++) ops_q.push_back(tbl[0].ops[8*j +: 8]);
    run_check("after_abort", tbl[0].iter, 1'b0, tbl[0].e_cls, tbl[0].e_cnt, tbl[0].e_tie, tbl[0].e_err);

    for (int r = 0; r < 25; r++) begin
      ops_q.delete();
      nit = $urandom_range(1, 3);
      for (int i = 0; i < nit; i++) begin
        nops = $urandom_range(0, 10);
        for (int j = 0; j <= nops; j++) begin
          op = '0;
          op[7] = ($urandom_range(0, 3) != 0);
          op[6] = ($urandom_range(0, 4) < 3);
          op[3:0] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
          if (j == nops) op[5] = 1'b1;
          ops_q.push_back(op);
        end
      end
      model();
      run_check($sformatf("rand%0d", r), 8'(nit), 1'b0, m_cls, m_cnt, m_tie, m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_vote_argmax.md
SPIKE_VOTE_ARGMAX -- requirements
Module: spike_vote_argmax

Interface
REQ-001 Parameter NUM_CLASSES, default 10: number of classifier output classes (spike ids 0..NUM_CLASSES-1).
REQ-002 Parameter CNT_W, default 8: width of each per-class vote counter.
REQ-003 Parameter ITER_W, default 8: width of iteration target and iteration counter.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset; asynchronous assertion, active-low (reset==0 resets).
REQ-006 start  input  1  one-cycle pulse; begins a new classification run.
REQ-007 iter_num  input  ITER_W  number of RBM iterations to accumulate; sampled only with an accepted start.
REQ-008 spike_valid  input  1  qualifies spike/spike_class; one classifier neuron result per asserted cycle.
REQ-009 spike  input  1  stochastic classifier output bit for spike_class.
REQ-010 spike_class  input  4  class index of the current spike.
REQ-011 iter_end  input  1  one-cycle pulse; the current RBM iteration has ended.
REQ-012 busy  output  1  high in ACCUM and SCAN.
REQ-013 done  output  1  one-cycle pulse; result outputs are valid.
REQ-014 pred_class  output  4  winning class index.
REQ-015 pred_count  output  CNT_W  vote count of the winning class.
REQ-016 tie  output  1  another class's count equals pred_count.
REQ-017 err  output  1  sticky; a spike_valid with spike_class >= NUM_CLASSES was seen during the run.

Function
REQ-018 States are IDLE, ACCUM, SCAN and DONE; DONE lasts exactly one cycle and always returns to IDLE.
REQ-019 In IDLE, start==1 shall clear all counters, the iteration counter, err and tie, latch iter_num, and enter ACCUM, or enter SCAN if iter_num==0.
REQ-020 start shall be ignored in ACCUM, SCAN and DONE.
REQ-021 In ACCUM, spike_valid && spike && spike_class<NUM_CLASSES shall increment counter[spike_class] by 1, saturating at 2^CNT_W-1.
REQ-022 spike_valid with spike==0 shall leave all counters unchanged.
REQ-023 spike_valid with spike_class>=NUM_CLASSES shall set err and leave all counters unchanged.
REQ-024 spike_valid and iter_end shall be ignored outside ACCUM.
REQ-025 In ACCUM, iter_end shall increment the iteration counter; when the incremented value equals the latched iter_num, the next state is SCAN.
REQ-026 When spike_valid and iter_end coincide, the spike shall be counted; it belongs to the ending iteration.
REQ-027 SCAN examines one class per cycle, index 0 to NUM_CLASSES-1, taking NUM_CLASSES cycles.
REQ-028 The best candidate starts as class 0 with tie=0.
REQ-029 A strictly greater count shall replace the best and clear tie; an equal count shall set tie and keep the lower index.
REQ-030 After the last index, the block enters DONE and asserts done for one cycle.
REQ-031 Latency: done is high during the 11th cycle after the edge that samples the final iter_end (NUM_CLASSES=10).
REQ-032 pred_class, pred_count, tie and err are updated only when entering DONE and are held until the next accepted start.
REQ-033 pred_class, pred_count, tie and err are unchanged while ACCUM and SCAN are in progress.
REQ-034 busy==1 exactly while in ACCUM or SCAN.

Reset
REQ-035 reset==0 shall immediately force IDLE and drive busy=0, done=0, pred_class=0, pred_count=0, tie=0, err=0, with all counters and the iteration counter cleared.
REQ-036 reset asserted mid-ACCUM or mid-SCAN shall abort the run without producing done.
REQ-037 After reset deasserts, the block shall accept start on the first rising edge.

Verification
REQ-038 start with iter_num=1; spikes of 1 on classes 3,3,7; iter_end -> done 11 cycles later; pred_class=3, pred_count=2, tie=0, err=0.
REQ-039 iter_num=2; class 5 spikes once per iteration, class 2 spikes twice in iteration 1 -> pred_class=2, pred_count=2, tie=1.
REQ-040 300 spikes on class 9 in one iteration -> pred_count=255 (saturated), pred_class=9.
REQ-041 spike_valid with spike_class=12, plus one spike on class 4 -> err=1, pred_class=4, pred_count=1; the next start clears err.
REQ-042 iter_num=0 -> done with pred_class=0, pred_count=0, tie=1; a second start while busy -> ignored, busy stays high.
REQ-043 reset pulled low during SCAN -> outputs are 0 immediately, no done pulse, and the next start runs normally.
